random_matrix_fill_ctrl: RTL and testbench

RANDOM_MATRIX_FILL_CTRL -- requirements
Module: random_matrix_fill_ctrl

---
 rtl/random_matrix_fill_ctrl.sv | 162 ++++++++++++++++
 tb/tb_random_matrix_fill_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/random_matrix_fill_ctrl.sv
// random_matrix_fill_ctrl
// Fills a rows x cols matrix in row-major order with samples from an external
// random number generator. Each sample is range-checked against the latched
// [min,max] window and re-requested up to RETRY_MAX times before giving up.
// Strobes (rng_en, wr_en, done, err) are registered and asserted in the cycle
// of the state they belong to, so they are glitch-free and mutually exclusive.
module random_matrix_fill_ctrl #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_DIM   = 5,
    parameter int unsigned RETRY_MAX = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       rows,
    input  logic [2:0]       cols,
    input  logic [WIDTH-1:0] min_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic [WIDTH-1:0] rng_num,
    output logic             rng_en,
    output logic [WIDTH-1:0] rng_min,
    output logic [WIDTH-1:0] rng_max,
    output logic             wr_en,
    output logic [2:0]       wr_row,
    output logic [2:0]       wr_col,
    output logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    localparam int unsigned RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
    localparam logic [2:0]    DIM_LIM   = 3'(MAX_DIM);

    logic [2:0]    state;
    logic [2:0]    rows_q;
    logic [2:0]    cols_q;
    logic [2:0]    row_cnt;
    logic [2:0]    col_cnt;
    logic [RW-1:0] retry_cnt;
    logic          cfg_bad;
    logic          in_range;
    logic          last_col;
    logic          last_elem;

    // Current write coordinates are the element counters themselves.
    assign wr_row = row_cnt;
    assign wr_col = col_cnt;

    // Configuration validity, sample range test and end-of-row/matrix detection.
    always_comb begin
        cfg_bad   = (rows_q == 3'd0) || (cols_q == 3'd0) ||
                    (rows_q > DIM_LIM) || (cols_q > DIM_LIM) ||
                    (rng_min > rng_max);
        in_range  = (rng_num >= rng_min) && (rng_num <= rng_max);
        last_col  = (col_cnt == cols_q - 3'd1);
        last_elem = last_col && (row_cnt == rows_q - 3'd1);
        busy      = (state != S_IDLE);
    end

    // Fill sequencer: abort overrides every transition; strobes default low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            row_cnt   <= '0;
            col_cnt   <= '0;
            retry_cnt <= '0;
            rng_min   <= '0;
            rng_max   <= '1;
            wr_data   <= '0;
            rng_en    <= 1'b0;
            wr_en     <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            rng_en <= 1'b0;
            wr_en  <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            if (abort && (state != S_IDLE)) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            rows_q  <= rows;
                            cols_q  <= cols;
                            rng_min <= min_val;
                            rng_max <= max_val;
                            state   <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (cfg_bad) begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            row_cnt   <= '0;
                            col_cnt   <= '0;
                            retry_cnt <= '0;
                            rng_en    <= 1'b1;
                            state     <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (in_range) begin
                            wr_data   <= rng_num;
                            retry_cnt <= '0;
                            wr_en     <= 1'b1;
                            state     <= S_WRITE;
                        end else if (retry_cnt < RETRY_LIM) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            rng_en    <= 1'b1;
                            state     <= S_REQ;
                        end else begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                    S_WRITE: begin
                        if (last_elem) begin
                            row_cnt <= '0;
                            col_cnt <= '0;
                            done    <= 1'b1;
                            state   <= S_FIN;
                        end else begin
                            if (last_col) begin
                                col_cnt <= '0;
                                row_cnt <= row_cnt + 3'd1;
                            end else begin
                                col_cnt <= col_cnt + 3'd1;
                            end
                            rng_en <= 1'b1;
                            state  <= S_REQ;
                        end
                    end
                    S_FIN: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_random_matrix_fill_ctrl.sv
// Self-checking bench for random_matrix_fill_ctrl: table of fill configurations
// plus hand-written retry, abort, busy-input and asynchronous-reset sequences.
module tb_random_matrix_fill_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [2:0] rows;
    logic [2:0] cols;
    logic [7:0] min_val;
    logic [7:0] max_val;
    logic [7:0] rng_num;
    logic       rng_en;
    logic [7:0] rng_min;
    logic [7:0] rng_max;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [2:0] wr_col;
    logic [7:0] wr_data;
    logic       busy;
    logic       done;
    logic       err;

    random_matrix_fill_ctrl #(
        .WIDTH(8),
        .MAX_DIM(5),
        .RETRY_MAX(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rows(rows), .cols(cols), .min_val(min_val), .max_val(max_val),
        .rng_num(rng_num), .rng_en(rng_en), .rng_min(rng_min), .rng_max(rng_max),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] r;
        logic [2:0] c;
        logic [7:0] mn;
        logic [7:0] mx;
        logic [7:0] rv;
        bit         disturb;
        bit         exp_err;
        int         exp_cyc;
        int         exp_wr;
    } vec_t;

    vec_t vecs[10];

    int n_cmp = 0;
    int n_bad = 0;

    // Bench-side model state
    int         wr_cnt, rng_cnt, done_cnt, err_cnt;
    int         exp_row, exp_col, cur_cols;
    logic [7:0] exp_data;
    logic [7:0] rng_dflt = 8'd0;
    logic [7:0] rng_q[$];
    int         tick = 0;
    int         last_wr_tick = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // RNG model, write-order scoreboard and strobe exclusivity monitor
    always @(negedge clk) begin
        tick++;
        if (rng_en) begin
            rng_cnt++;
            if (rng_q.size() > 0) rng_num = rng_q.pop_front();
            else                  rng_num = rng_dflt;
        end
        if (wr_en) begin
            wr_cnt++;
            check("wr_row", int'(wr_row), exp_row);
            check("wr_col", int'(wr_col), exp_col);
            check("wr_data", int'(wr_data), int'(exp_data));
            if (wr_cnt > 1) check("wr_spacing", tick - last_wr_tick, 3);
            last_wr_tick = tick;
            if (exp_col == cur_cols - 1) begin
                exp_col = 0;
                exp_row++;
            end else begin
                exp_col++;
            end
        end
        if (done) done_cnt++;
        if (err)  err_cnt++;
        if (rng_en || wr_en || done || err)
            check("strobe_exclusive", int'(rng_en) + int'(wr_en) + int'(done) + int'(err), 1);
    end

    // Pulse start for one cycle; returns at the negedge of the first cycle after start.
    task automatic begin_fill(input logic [2:0] r, input logic [2:0] c,
                              input logic [7:0] mn, input logic [7:0] mx,
                              input logic [7:0] edata);
        @(negedge clk);
        rows = r; cols = c; min_val = mn; max_val = mx; start = 1'b1;
        wr_cnt = 0; rng_cnt = 0; done_cnt = 0; err_cnt = 0;
        exp_row = 0; exp_col = 0; cur_cols = int'(c); exp_data = edata;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_fill(input string name, input logic [2:0] r, input logic [2:0] c,
                            input logic [7:0] mn, input logic [7:0] mx, input bit disturb,
                            input bit exp_err, input int exp_cyc, input int exp_wr,
                            input int exp_rng, input logic [7:0] edata);
        int cyc;
        int end_cyc;
        bit got_err;
        bit busy_held;
        begin_fill(r, c, mn, mx, edata);
        cyc = 1; end_cyc = -1; got_err = 1'b0; busy_held = 1'b1;
        while (cyc <= 200) begin
            if (done || err) begin
                end_cyc = cyc;
                got_err = err;
                break;
            end
            if (!busy) busy_held = 1'b0;
            if (disturb) begin
                start = cyc[0];
                rows = 3'(cyc); cols = 3'(cyc + 3);
                min_val = 8'hff; max_val = 8'h00;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({name, "_end_cycle"}, end_cyc, exp_cyc);
        check({name, "_err"}, int'(got_err), int'(exp_err));
        check({name, "_busy_held"}, int'(busy_held), 1);
        check({name, "_busy_at_end"}, int'(busy), exp_err ? 0 : 1);
        check({name, "_rng_min"}, int'(rng_min), int'(mn));
        check({name, "_rng_max"}, int'(rng_max), int'(mx));
        @(negedge clk);
        check({name, "_busy_after"}, int'(busy), 0);
        check({name, "_wr_count"}, wr_cnt, exp_wr);
        check({name, "_rng_count"}, rng_cnt, exp_rng);
        check({name, "_done_count"}, done_cnt, exp_err ? 0 : 1);
        check({name, "_err_count"}, err_cnt, exp_err ? 1 : 0);
    endtask

    initial begin
        //          r     c     mn     mx     rv     dist  err  cyc wr
        vecs[0] = '{3'd2, 3'd3, 8'd0,  8'd15, 8'd7,  1'b0, 1'b0, 20, 6};
        vecs[1] = '{3'd0, 3'd3, 8'd0,  8'd15, 8'd5,  1'b0, 1'b1, 2,  0};
        vecs[2] = '{3'd2, 3'd6, 8'd0,  8'd15, 8'd5,  1'b0, 1'b1, 2,  0};
        vecs[3] = '{3'd2, 3'd2, 8'd9,  8'd3,  8'd5,  1'b0, 1'b1, 2,  0};
        vecs[4] = '{3'd6, 3'd1, 8'd0,  8'd255,8'd5,  1'b0, 1'b1, 2,  0};
        vecs[5] = '{3'd1, 3'd1, 8'd0,  8'd255,8'd255,1'b0, 1'b0, 5,  1};
        vecs[6] = '{3'd5, 3'd5, 8'd10, 8'd20, 8'd10, 1'b0, 1'b0, 77, 25};
        vecs[7] = '{3'd3, 3'd1, 8'd7,  8'd7,  8'd7,  1'b0, 1'b0, 11, 3};
        vecs[8] = '{3'd2, 3'd2, 8'd0,  8'd15, 8'd9,  1'b1, 1'b0, 14, 4};
        vecs[9] = '{3'd1, 3'd7, 8'd0,  8'd15, 8'd5,  1'b0, 1'b1, 2,  0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        rows = '0; cols = '0; min_val = '0; max_val = '0; rng_num = '0;
        wr_cnt = 0; rng_cnt = 0; done_cnt = 0; err_cnt = 0;
        exp_row = 0; exp_col = 0; cur_cols = 1; exp_data = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_rng_en", int'(rng_en), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_rng_min", int'(rng_min), 0);
        check("rst_rng_max", int'(rng_max), 255);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            rng_dflt = vecs[i].rv;
            run_fill($sformatf("vec%0d", i), vecs[i].r, vecs[i].c, vecs[i].mn, vecs[i].mx,
                     vecs[i].disturb, vecs[i].exp_err, vecs[i].exp_cyc,
                     vecs[i].exp_wr, vecs[i].exp_wr, vecs[i].rv);
        end

        // Two out-of-range samples, then an in-range one
        rng_q = '{8'd2, 8'd9, 8'd5};
        run_fill("retry_ok", 3'd1, 3'd1, 8'd4, 8'd8, 1'b0, 1'b0, 9, 1, 3, 8'd5);

        // Every sample out of range: initial request plus three retries, then err
        rng_dflt = 8'd20;
        run_fill("retry_exhaust", 3'd1, 3'd1, 8'd4, 8'd8, 1'b0, 1'b1, 10, 0, 4, 8'd0);

        // Abort in the cycle of the third write of a 3x3 fill
        rng_dflt = 8'd3;
        begin_fill(3'd3, 3'd3, 8'd0, 8'd15, 8'd3);
        repeat (9) @(negedge clk);
        check("abort_third_wr_en", int'(wr_en), 1);
        check("abort_third_wr_col", int'(wr_col), 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy_next", int'(busy), 0);
        check("abort_rng_en_next", int'(rng_en), 0);
        repeat (12) @(negedge clk);
        check("abort_wr_count", wr_cnt, 3);
        check("abort_done_count", done_cnt, 0);
        check("abort_err_count", err_cnt, 0);
        run_fill("after_abort", 3'd1, 3'd2, 8'd0, 8'd15, 1'b0, 1'b0, 8, 2, 2, 8'd3);

        // Start and abort together in IDLE: start ignored
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", int'(busy), 0);
        @(negedge clk);
        check("start_abort_err", int'(err), 0);

        // Asynchronous reset while wr_en is high
        rng_dflt = 8'd3;
        begin_fill(3'd2, 3'd2, 8'd1, 8'd15, 8'd3);
        repeat (3) @(negedge clk);
        check("areset_pre_wr_en", int'(wr_en), 1);
        #2 rst_n = 1'b0;
        #1;
        check("areset_busy", int'(busy), 0);
        check("areset_wr_en", int'(wr_en), 0);
        check("areset_rng_en", int'(rng_en), 0);
        check("areset_done", int'(done), 0);
        check("areset_err", int'(err), 0);
        check("areset_wr_row", int'(wr_row), 0);
        check("areset_wr_col", int'(wr_col), 0);
        check("areset_wr_data", int'(wr_data), 0);
        check("areset_rng_min", int'(rng_min), 0);
        check("areset_rng_max", int'(rng_max), 255);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("areset_wr_count", wr_cnt, 1);
        check("areset_rng_count", rng_cnt, 1);
        check("areset_idle", int'(busy), 0);
        run_fill("after_reset", 3'd2, 3'd2, 8'd0, 8'd15, 1'b0, 1'b0, 14, 4, 4, 8'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
